// File: rtl/muldiv_unit_if.sv
// Bundles the EX-stage request, hazard handshake and HI/LO result signals of the mul/div unit.
// master = EX/hazard side driving requests, slave = the mul/div unit itself.
interface muldiv_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        ex_stall;
    logic        flush;
    logic        ALU_stall;
    logic        ALU_done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    modport master (
        output start, op, src_a, src_b, ex_stall, flush,
        input  ALU_stall, ALU_done, hi, lo, busy
    );

    modport slave (
        input  start, op, src_a, src_b, ex_stall, flush,
        output ALU_stall, ALU_done, hi, lo, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; MUL takes MUL_CYCLES+1, DIV 33 cycles to ALU_done.
// Holds ALU_stall while busy; completion is held in HOLD while EX is frozen; flush aborts.
module muldiv_unit #(
    parameter int MUL_CYCLES = 2
) (
    input  logic          clk,
    input  logic          resetn,
    muldiv_unit_if.slave  bus
);
    // Restoring divider always runs the full 32 iterations.
    localparam int DIV_CYCLES = 32;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_DONE, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] opa_q, opa_d;   // raw src_a (mult operand, or dividend for div-by-zero)
    logic [31:0] opb_q, opb_d;   // raw src_b for mult, |divisor| for div
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;   // dividend shifts out as quotient shifts in
    logic        sgn_q, sgn_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic        done_q, done_d;

    logic        is_md_op;
    logic [31:0] a_abs, b_abs;
    logic        a_neg, b_neg;
    logic [63:0] mul_a, mul_b, product;
    logic [32:0] rem_shift, rem_diff;
    logic        step_ok;
    logic [31:0] rem_next, quo_next;

    assign is_md_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                      (bus.op == OP_DIV)  || (bus.op == OP_DIVU);

    assign a_neg = (bus.op == OP_DIV) && bus.src_a[31];
    assign b_neg = (bus.op == OP_DIV) && bus.src_b[31];
    assign a_abs = a_neg ? (32'd0 - bus.src_a) : bus.src_a;
    assign b_abs = b_neg ? (32'd0 - bus.src_b) : bus.src_b;

    // Sign-extend to 64 bits so the low 64 product bits are correct for both signednesses.
    assign mul_a   = {{32{sgn_q & opa_q[31]}}, opa_q};
    assign mul_b   = {{32{sgn_q & opb_q[31]}}, opb_q};
    assign product = mul_a * mul_b;

    assign rem_shift = {rem_q, quo_q[31]};
    assign rem_diff  = rem_shift - {1'b0, opb_q};
    assign step_ok   = ~rem_diff[32];
    assign rem_next  = step_ok ? rem_diff[31:0] : rem_shift[31:0];
    assign quo_next  = {quo_q[30:0], step_ok};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        sgn_d   = sgn_q;
        negq_d  = negq_q;
        negr_d  = negr_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            state_d = S_MUL;
                            cnt_d   = 5'(MUL_CYCLES - 1);
                            sgn_d   = (bus.op == OP_MULT);
                            opa_d   = bus.src_a;
                            opb_d   = bus.src_b;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = S_DIV;
                            cnt_d   = 5'(DIV_CYCLES - 1);
                            sgn_d   = (bus.op == OP_DIV);
                            opa_d   = bus.src_a;
                            opb_d   = b_abs;
                            quo_d   = a_abs;
                            rem_d   = 32'd0;
                            negq_d  = a_neg ^ b_neg;
                            negr_d  = a_neg;
                        end
                        OP_MTHI: hi_d = bus.src_a;
                        OP_MTLO: lo_d = bus.src_a;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 5'd0) begin
                    {hi_d, lo_d} = product;
                    state_d      = S_DONE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_DIV: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_next;
                    quo_d = quo_next;
                    if (cnt_q == 5'd0) begin
                        if (opb_q == 32'd0) begin
                            lo_d = 32'hFFFF_FFFF;
                            hi_d = opa_q;
                        end else begin
                            lo_d = negq_q ? (32'd0 - quo_next) : quo_next;
                            hi_d = negr_q ? (32'd0 - rem_next) : rem_next;
                        end
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end
            S_DONE: begin
                if (bus.flush)         state_d = S_IDLE;
                else if (bus.ex_stall) state_d = S_HOLD;
                else                   state_d = S_IDLE;
            end
            S_HOLD: begin
                if (bus.flush || !bus.ex_stall) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        done_d = (state_d == S_DONE) || (state_d == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            sgn_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            sgn_q   <= sgn_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            done_q  <= done_d;
        end
    end

    // DONE/HOLD keep stall high; the hazard controller masks it with ALU_done.
    always_comb begin
        bus.ALU_stall = 1'b0;
        case (state_q)
            S_IDLE:                        bus.ALU_stall = bus.start && is_md_op;
            S_MUL, S_DIV, S_DONE, S_HOLD:  bus.ALU_stall = 1'b1;
            default:                       bus.ALU_stall = 1'b0;
        endcase
        bus.ALU_stall = bus.ALU_stall && resetn;
    end

    assign bus.ALU_done = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = (state_q == S_MUL) || (state_q == S_DIV);
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage. Owns the HI/LO registers.
- Requester side of the ALU_stall/ALU_done handshake consumed by the hazard/stall controller.
- Raises ALU_stall while a MULT/MULTU/DIV/DIVU is in flight, pulses ALU_done on completion, and holds completion while EX is frozen by other hazards.
- Aborts cleanly on an exception flush.

Parameters:
- MUL_CYCLES, 2, cycles spent in MUL state (1..4); models the registered DSP multiplier.
- DIV_CYCLES, 32, restoring-division iterations; fixed at 32 and not to be overridden.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  valid mul/div-class op present in EX.
- op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treat as none).
- src_a  in  32  rs operand.
- src_b  in  32  rt operand.
- ex_stall  in  1  StallE from the hazard controller.
- flush  in  1  exception clean; abort and discard.
- ALU_stall  out  1  unit requires EX to hold.
- ALU_done  out  1  result committed to HI/LO for the op in EX.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  state is MUL or DIV.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE; hi=lo=0; ALU_done=0; busy=0.
  - ALU_stall is forced to 0 while resetn=0, including mid-operation; the partial result is dropped.
- States: IDLE, MUL, DIV, DONE, HOLD.
- IDLE:
  - start with op MULT/MULTU: latch operands and signedness, go to MUL, counter=MUL_CYCLES-1.
  - start with op DIV/DIVU: latch |a|, |b| (or raw values when unsigned) plus sign bits, go to DIV, counter=31.
  - start with op MTHI/MTLO: write hi/lo from src_a at this edge, single cycle, no stall, stay IDLE.
  - Otherwise stay IDLE.
- MUL: decrement counter; at 0, write {hi,lo} = 64-bit product (signed or unsigned) and go to DONE.
- DIV:
  - One restoring step per cycle: shift the remainder left by one, bring in the next dividend bit, trial-subtract the divisor, set the quotient bit.
  - After the 32nd step, apply signs and write the results, then go to DONE.
  - Signs: quotient negative iff sign(a)^sign(b); remainder takes sign(a).
  - Results: lo=quotient, hi=remainder.
  - Divide by zero, both DIV and DIVU: lo=0xFFFFFFFF, hi=src_a unchanged.
  - 0x80000000 / 0xFFFFFFFF signed: lo=0x80000000, hi=0.
- DONE: ALU_done=1 for this cycle. If ex_stall=1, go to HOLD; else go to IDLE.
- HOLD: ALU_done stays 1; the unit must not restart on the still-present start. Leave to IDLE when ex_stall=0.
- ALU_stall is combinational:
  - 1 in IDLE when start and op is in 001..100;
  - 1 in MUL and DIV;
  - 1 in DONE and HOLD, where the controller gates it with ALU_done;
  - 0 otherwise.
- ALU_done is registered and is 1 only in DONE and HOLD.
- Latency, counted from the IDLE edge that accepts start:
  - DIV: ALU_done high in cycle 33.
  - MUL: ALU_done high in cycle MUL_CYCLES+1.
- flush:
  - In MUL or DIV: go to IDLE next edge, hi/lo untouched, no ALU_done.
  - In DONE or HOLD: go to IDLE. hi/lo are already committed; the exception logic guarantees the flushed op is older than the commit point.
  - In IDLE together with start: start is ignored.
  - flush has priority over every other transition.
- MTHI/MTLO while busy cannot occur: EX is held. If op changes mid-operation, the change is ignored and the latched op governs.

Test Plan:
- Reset mid-DIV: issue DIVU 100/7, assert resetn=0 at iteration 10 → hi=lo=0, ALU_stall=0, ALU_done never pulses.
- DIVU 100/7 → ALU_stall=1 for cycles 0..32, ALU_done=1 in cycle 33 only, lo=14, hi=2.
- DIV 0xFFFFFFF9(-7)/2 → lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0; DIVU 5/0 → lo=0xFFFFFFFF, hi=5.
- MULT 0xFFFFFFFF × 3 with MUL_CYCLES=2 → ALU_done in cycle 3, hi=0xFFFFFFFF, lo=0xFFFFFFFD; MULTU same operands → hi=2, lo=0xFFFFFFFD.
- DIV completes with ex_stall=1 held for 4 cycles and start still high → state HOLD, ALU_done stays 1 for 5 cycles, no second division, IDLE after ex_stall drops.
- flush at DIV iteration 20, then MTLO 0x1234 → prior hi/lo preserved, lo=0x1234 the next cycle, ALU_stall=0 throughout the MTLO.
